rename_ckpt: RTL and testbench

Parametrised register-rename stage with multi-level branch checkpointing, sitting between the decode skid buffer and dispatch. It maps architectural to physical registers through an internal map table and circular free list, and assigns ROB tags. It holds up to NUM_CKPT outstanding branch snapshots. Branch resolution arrives in program order from the back end: a correct prediction retires the oldest snapshot, and a misprediction restores state from it in one cycle.

---
 rtl/rename_ckpt.sv | 248 ++++++++++++++++++++++++
 tb/tb_rename_ckpt.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_ckpt.sv
// rename_ckpt -- register-rename stage with multi-level branch checkpointing.
//
// Sits between the decode skid buffer and dispatch. Architectural registers are
// mapped to physical registers through a map table and a circular free list;
// each accepted instruction receives a ROB tag. Up to NUM_CKPT branch snapshots
// (map, free-list read pointer, next ROB tag) are held in a ring. Branches
// resolve in program order: a correct prediction releases the oldest snapshot,
// a misprediction restores state from it in one cycle and drops all snapshots.
//
// Handshake: data_in transfers on a cycle where valid_in & ready_in are both
// high; data_out transfers on a cycle where valid_out & ready_out are both
// high. valid_out and data_out stay stable while valid_out & !ready_out.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   valid_in, data_in, ready_in  decoded instruction input and handshake
//   commit_valid, commit_pd_old  retirement frees commit_pd_old (0 ignored)
//   br_resolve_valid             oldest outstanding branch resolved
//   br_mispredict                1 = restore from oldest snapshot, 0 = release
//   data_out, valid_out, ready_out  renamed instruction and handshake
//   br_tag_out                   snapshot slot of a branch in data_out, else 0
//   free_count                   free physical registers
//   ckpt_count                   outstanding snapshots
//
// data_in layout, MSB first:
//   pc[32] imm[32] func7[7] func3[3] alu_op[4] fu_type[4] opcode[7] rd rs2 rs1
// data_out layout, MSB first:
//   pc imm func7 func3 alu_op fu_type opcode rd pd_new pd_old ps2 ps1 rob_tag
module rename_ckpt #(
    parameter  int ARCH_REGS = 32,
    parameter  int PHYS_REGS = 128,
    parameter  int ROB_TAG_W = 4,
    parameter  int NUM_CKPT  = 4,
    localparam int AREG_W    = $clog2(ARCH_REGS),
    localparam int PREG_W    = $clog2(PHYS_REGS),
    localparam int CKPT_W    = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
    localparam int DEC_W     = 89 + 3 * AREG_W,
    localparam int REN_W     = 89 + AREG_W + 4 * PREG_W + ROB_TAG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [DEC_W-1:0]  data_in,
    output logic              ready_in,
    input  logic              commit_valid,
    input  logic [PREG_W-1:0] commit_pd_old,
    input  logic              br_resolve_valid,
    input  logic              br_mispredict,
    output logic [REN_W-1:0]  data_out,
    output logic [CKPT_W-1:0] br_tag_out,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [PREG_W:0]   free_count,
    output logic [CKPT_W:0]   ckpt_count
);

    localparam logic [6:0]        OP_STORE  = 7'b0100011;
    localparam logic [6:0]        OP_BRANCH = 7'b1100011;
    localparam logic [CKPT_W:0]   CKPT_FULL = (CKPT_W + 1)'(NUM_CKPT);
    localparam logic [CKPT_W-1:0] CKPT_LAST = CKPT_W'(NUM_CKPT - 1);

    // Decoded input fields
    logic [31:0]       in_pc, in_imm;
    logic [6:0]        in_func7;
    logic [2:0]        in_func3;
    logic [3:0]        in_alu_op, in_fu_type;
    logic [6:0]        in_opcode;
    logic [AREG_W-1:0] in_rd, in_rs2, in_rs1;

    assign {in_pc, in_imm, in_func7, in_func3, in_alu_op, in_fu_type,
            in_opcode, in_rd, in_rs2, in_rs1} = data_in;

    // Architectural state
    logic [PREG_W-1:0]    map_q [ARCH_REGS];
    logic [PREG_W-1:0]    fl_q  [PHYS_REGS];
    logic [PREG_W:0]      rd_ptr_q, rd_ptr_d;
    logic [PREG_W:0]      wr_ptr_q, wr_ptr_d;
    logic [ROB_TAG_W-1:0] ctr_q, ctr_d;

    // Snapshot ring
    logic [CKPT_W-1:0]    ck_head_q, ck_head_d;
    logic [CKPT_W-1:0]    ck_tail_q, ck_tail_d;
    logic [CKPT_W:0]      ck_cnt_q, ck_cnt_d;
    logic [PREG_W-1:0]    snap_map_q [NUM_CKPT][ARCH_REGS];
    logic [PREG_W:0]      snap_rd_q  [NUM_CKPT];
    logic [ROB_TAG_W-1:0] snap_ctr_q [NUM_CKPT];

    // Output register
    logic              valid_q, valid_d;
    logic [REN_W-1:0]  data_q, data_d;
    logic [CKPT_W-1:0] tag_q, tag_d;

    logic              is_branch, write_pd, accept, alloc, take_ckpt;
    logic              restore, release_ck, do_commit;
    logic [PREG_W-1:0] pd_new, pd_old, ps1, ps2;

    function automatic logic [CKPT_W-1:0] ck_inc(input logic [CKPT_W-1:0] p);
        return (p == CKPT_LAST) ? '0 : p + 1'b1;
    endfunction

    assign is_branch = (in_opcode == OP_BRANCH);
    assign write_pd  = (in_opcode != OP_STORE) && !is_branch && (in_rd != '0);

    // A resolve with no outstanding snapshot is ignored entirely.
    assign restore    = br_resolve_valid &&  br_mispredict && (ck_cnt_q != '0);
    assign release_ck = br_resolve_valid && !br_mispredict && (ck_cnt_q != '0);
    assign do_commit  = commit_valid && (commit_pd_old != '0);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign free_count = wr_ptr_q - rd_ptr_q;

    // Uses registered counts only: a same-cycle commit or resolve never
    // bypasses into acceptance.
    assign ready_in = (ready_out || !valid_q)
                   && (!write_pd  || free_count != '0)
                   && (!is_branch || ck_cnt_q != CKPT_FULL)
                   && !(br_resolve_valid && br_mispredict);

    assign accept    = valid_in && ready_in;
    assign alloc     = accept && write_pd;
    assign take_ckpt = accept && is_branch;

    assign pd_new = write_pd ? fl_q[rd_ptr_q[PREG_W-1:0]] : '0;
    assign pd_old = map_q[in_rd];
    assign ps1    = map_q[in_rs1];
    assign ps2    = map_q[in_rs2];

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        ctr_d     = ctr_q;
        ck_head_d = ck_head_q;
        ck_tail_d = ck_tail_q;
        ck_cnt_d  = ck_cnt_q;
        valid_d   = valid_q;
        data_d    = data_q;
        tag_d     = tag_q;

        // The write pointer is never checkpointed, so commits survive a restore.
        if (do_commit) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (restore) begin
            rd_ptr_d  = snap_rd_q[ck_head_q];
            ctr_d     = snap_ctr_q[ck_head_q];
            ck_head_d = ck_tail_q;
            ck_cnt_d  = '0;
            valid_d   = 1'b0;
        end else begin
            if (accept) begin
                ctr_d   = ctr_q + 1'b1;
                valid_d = 1'b1;
                data_d  = {in_pc, in_imm, in_func7, in_func3, in_alu_op,
                           in_fu_type, in_opcode, in_rd, pd_new, pd_old,
                           ps2, ps1, ctr_q};
                tag_d   = is_branch ? ck_tail_q : '0;
                if (alloc) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (take_ckpt) begin
                    ck_tail_d = ck_inc(ck_tail_q);
                end
            end else if (ready_out) begin
                valid_d = 1'b0;
            end

            if (release_ck) begin
                ck_head_d = ck_inc(ck_head_q);
            end

            case ({take_ckpt, release_ck})
                2'b10:   ck_cnt_d = ck_cnt_q + 1'b1;
                2'b01:   ck_cnt_d = ck_cnt_q - 1'b1;
                default: ck_cnt_d = ck_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= (PREG_W + 1)'(PHYS_REGS - ARCH_REGS);
            ctr_q     <= '0;
            ck_head_q <= '0;
            ck_tail_q <= '0;
            ck_cnt_q  <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            tag_q     <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            ctr_q     <= ctr_d;
            ck_head_q <= ck_head_d;
            ck_tail_q <= ck_tail_d;
            ck_cnt_q  <= ck_cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
        end
    end

    // Map table: identity after reset, bulk reload on restore.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= PREG_W'(i);
            end
        end else if (restore) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= snap_map_q[ck_head_q][i];
            end
        end else if (alloc) begin
            map_q[in_rd] <= pd_new;
        end
    end

    // Free-list storage: ARCH_REGS..PHYS_REGS-1 in ascending order after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                fl_q[i] <= (i < PHYS_REGS - ARCH_REGS) ? PREG_W'(i + ARCH_REGS) : '0;
            end
        end else if (do_commit) begin
            fl_q[wr_ptr_q[PREG_W-1:0]] <= commit_pd_old;
        end
    end

    // Snapshot payload is only read behind a nonzero count, so it needs no reset.
    // A branch allocates nothing, so the current map and read pointer are
    // already the post-branch state.
    always_ff @(posedge clk) begin
        if (take_ckpt) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                snap_map_q[ck_tail_q][i] <= map_q[i];
            end
            snap_rd_q[ck_tail_q]  <= rd_ptr_q;
            snap_ctr_q[ck_tail_q] <= ctr_q + 1'b1;
        end
    end

    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign br_tag_out = tag_q;
    assign ckpt_count = ck_cnt_q;

endmodule

// File: tb/tb_rename_ckpt.sv
module tb_rename_ckpt;

  localparam int DEC_W    = 104;
  localparam int REN_W    = 126;
  localparam int NUM_CKPT = 4;
  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             valid_in = 1'b0;
  logic [DEC_W-1:0] data_in = '0;
  logic             ready_in;
  logic             commit_valid = 1'b0;
  logic [6:0]       commit_pd_old = '0;
  logic             br_resolve_valid = 1'b0;
  logic             br_mispredict = 1'b0;
  logic [REN_W-1:0] data_out;
  logic [1:0]       br_tag_out;
  logic             valid_out;
  logic             ready_out = 1'b1;
  logic [7:0]       free_count;
  logic [2:0]       ckpt_count;

  always #5 clk = ~clk;

  rename_ckpt dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .valid_in         (valid_in),
    .data_in          (data_in),
    .ready_in         (ready_in),
    .commit_valid     (commit_valid),
    .commit_pd_old    (commit_pd_old),
    .br_resolve_valid (br_resolve_valid),
    .br_mispredict    (br_mispredict),
    .data_out         (data_out),
    .br_tag_out       (br_tag_out),
    .valid_out        (valid_out),
    .ready_out        (ready_out),
    .free_count       (free_count),
    .ckpt_count       (ckpt_count)
  );

  logic [6:0] o_pdnew, o_ps1;
  logic [3:0] o_rob;
  assign o_pdnew = data_out[31:25];
  assign o_ps1   = data_out[10:4];
  assign o_rob   = data_out[3:0];

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Free list is an ordered queue of free pregs; every allocation is logged so
  // a restore can hand speculative allocations back to the head of the list.
  typedef struct packed {
    logic [31:0][6:0] map;
    logic [31:0]      ctr;
    logic [31:0]      nhist;
  } ck_t;

  logic [31:0][6:0] m_map;
  logic [6:0]       m_free[$];
  logic [6:0]       m_hist[$];
  ck_t              m_ck[$];
  int               m_ctr;
  int               m_nbr;
  logic [127:0]     exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = 7'(i);
    m_free.delete();
    for (int i = 32; i < 128; i++) m_free.push_back(7'(i));
    m_hist.delete();
    m_ck.delete();
    exp_q.delete();
    m_ctr = 0;
    m_nbr = 0;
  endtask

  function automatic bit model_ready();
    logic [6:0] op;
    logic [4:0] rd;
    bit wp, br;
    op = data_in[21:15];
    rd = data_in[14:10];
    br = (op == OP_BR);
    wp = (op != OP_ST) && !br && (rd != 5'd0);
    return (ready_out || exp_q.size() == 0) && (!wp || m_free.size() != 0)
        && (!br || m_ck.size() != NUM_CKPT) && !(br_resolve_valid && br_mispredict);
  endfunction

  task automatic model_step();
    logic [6:0] op, pdn, pdo, p1, p2;
    logic [4:0] rd, rs1, rs2;
    logic [1:0] tag;
    bit rdy, wp, br;
    ck_t ck;
    op  = data_in[21:15];
    rd  = data_in[14:10];
    rs2 = data_in[9:5];
    rs1 = data_in[4:0];
    br  = (op == OP_BR);
    wp  = (op != OP_ST) && !br && (rd != 5'd0);
    rdy = model_ready();
    if (exp_q.size() != 0 && ready_out) void'(exp_q.pop_front());
    if (valid_in && rdy) begin
      p1  = m_map[rs1];
      p2  = m_map[rs2];
      pdo = m_map[rd];
      pdn = 7'd0;
      if (wp) begin
        pdn = m_free.pop_front();
        m_map[rd] = pdn;
        m_hist.push_back(pdn);
      end
      tag = br ? 2'(m_nbr % NUM_CKPT) : 2'd0;
      exp_q.push_back({tag, data_in[103:15], rd, pdn, pdo, p2, p1, 4'(m_ctr % 16)});
      if (br) begin
        ck.map   = m_map;
        ck.ctr   = 32'(m_ctr + 1);
        ck.nhist = 32'(m_hist.size());
        m_ck.push_back(ck);
        m_nbr++;
      end
      m_ctr++;
    end
    if (br_resolve_valid && m_ck.size() != 0) begin
      if (br_mispredict) begin
        ck    = m_ck[0];
        m_map = ck.map;
        m_ctr = int'(ck.ctr);
        while (m_hist.size() > int'(ck.nhist)) m_free.push_front(m_hist.pop_back());
        m_ck.delete();
        exp_q.delete();
      end else begin
        void'(m_ck.pop_front());
      end
    end
    if (commit_valid && commit_pd_old != 7'd0) m_free.push_back(commit_pd_old);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid_out", valid_out, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("data_out", data_out, exp_q[0][125:0]);
        check("br_tag_out", br_tag_out, exp_q[0][127:126]);
      end
      if (!reset_n) begin
        check("rst_data_out", data_out, 0);
        check("rst_br_tag", br_tag_out, 0);
      end
      check("ready_in", ready_in, model_ready());
      check("free_count", free_count, m_free.size());
      check("ckpt_count", ckpt_count, m_ck.size());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    data_in = '0;
    commit_valid = 1'b0;
    commit_pd_old = '0;
    br_resolve_valid = 1'b0;
    br_mispredict = 1'b0;
    ready_out = 1'b1;
  endtask

  function automatic logic [DEC_W-1:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] pc, imm;
    pc  = $urandom_range(32'h0000_ffff, 0);
    imm = $urandom_range(32'h0000_0fff, 0);
    return {pc, imm, 7'h20, 3'd2, 4'd5, 4'd3, op, rd, rs2, rs1};
  endfunction

  task automatic send(input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2);
    valid_in = 1'b1;
    data_in = mk(op, rd, rs1, rs2);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    cyc();
    cyc();
    check("reset valid_out", valid_out, 0);
    check("reset data_out", data_out, 0);
    check("reset br_tag", br_tag_out, 0);
    check("reset free_count", free_count, 96);
    check("reset ckpt_count", ckpt_count, 0);
    reset_n = 1'b1;
  endtask

  logic [REN_W-1:0] held;

  initial begin
    idle();
    cyc();
    cmp_en = 1'b1;
    do_reset();

    // 96 writers drain the free list in ascending order
    for (int i = 0; i < 96; i++) begin
      send(OP_ADD, 5'((i % 31) + 1), 5'((i + 3) % 32), 5'((i + 7) % 32));
      cyc();
      check("fill pd_new", o_pdnew, 32 + i);
      check("fill rob_tag", o_rob, i % 16);
    end
    check("drained free_count", free_count, 0);
    send(OP_ADD, 5'd4, 5'd1, 5'd2);
    #1;
    check("97th writer ready_in", ready_in, 0);
    send(OP_ST, 5'd4, 5'd1, 5'd2);
    #1;
    check("store at empty ready_in", ready_in, 1);
    cyc();
    check("store pd_new", o_pdnew, 0);
    check("store rob_tag", o_rob, 0);

    // Commit at empty does not bypass; freed preg is reused next
    send(OP_ADD, 5'd3, 5'd0, 5'd0);
    commit_valid = 1'b1;
    commit_pd_old = 7'd5;
    #1;
    check("commit no bypass ready_in", ready_in, 0);
    cyc();
    check("after commit free_count", free_count, 1);
    valid_in = 1'b0;
    commit_pd_old = 7'd0;
    cyc();
    check("commit zero free_count", free_count, 1);
    commit_valid = 1'b0;
    send(OP_ADD, 5'd3, 5'd0, 5'd0);
    cyc();
    check("reuse pd_new", o_pdnew, 5);
    check("reuse free_count", free_count, 0);
    idle();
    cyc();

    // Branch snapshot then mispredict restore
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(OP_ST, 5'd0, 5'd1, 5'd2);
      cyc();
    end
    send(OP_BR, 5'd0, 5'd1, 5'd2);
    cyc();
    check("branch tag", br_tag_out, 0);
    check("branch rob_tag", o_rob, 3);
    check("branch ckpt_count", ckpt_count, 1);
    send(OP_ADD, 5'd1, 5'd2, 5'd3);
    cyc();
    check("spec add pd_new", o_pdnew, 32);
    check("spec add rob_tag", o_rob, 4);
    valid_in = 1'b0;
    commit_valid = 1'b1;
    commit_pd_old = 7'd7;
    cyc();
    check("commit7 free_count", free_count, 96);
    commit_valid = 1'b0;
    br_resolve_valid = 1'b1;
    br_mispredict = 1'b1;
    send(OP_ADD, 5'd2, 5'd1, 5'd1);
    #1;
    check("mispredict ready_in", ready_in, 0);
    cyc();
    check("restore valid_out", valid_out, 0);
    check("restore ckpt_count", ckpt_count, 0);
    check("restore free_count", free_count, 97);
    br_resolve_valid = 1'b0;
    br_mispredict = 1'b0;
    cyc();
    check("post-restore pd_new", o_pdnew, 32);
    check("post-restore rob_tag", o_rob, 4);
    check("post-restore ps1", o_ps1, 1);
    idle();
    cyc();

    // Checkpoint ring full, release, slot reuse
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(OP_BR, 5'(i), 5'd1, 5'd2);
      cyc();
      check("ring br_tag", br_tag_out, i);
    end
    check("ring full count", ckpt_count, 4);
    br_resolve_valid = 1'b1;
    #1;
    check("full+resolve ready_in", ready_in, 0);
    cyc();
    check("released count", ckpt_count, 3);
    br_resolve_valid = 1'b0;
    cyc();
    check("fifth branch slot", br_tag_out, 0);
    check("fifth branch count", ckpt_count, 4);
    valid_in = 1'b0;
    br_resolve_valid = 1'b1;
    cyc();
    check("release count", ckpt_count, 3);
    send(OP_BR, 5'd9, 5'd1, 5'd2);
    cyc();
    check("resolve+branch slot", br_tag_out, 1);
    check("resolve+branch count", ckpt_count, 3);
    valid_in = 1'b0;
    br_mispredict = 1'b1;
    cyc();
    check("flush count", ckpt_count, 0);
    idle();
    cyc();

    // Output stall holds data and blocks allocation
    do_reset();
    ready_out = 1'b0;
    send(OP_ADD, 5'd5, 5'd1, 5'd2);
    cyc();
    check("stall first valid", valid_out, 1);
    held = data_out;
    send(OP_ADD, 5'd6, 5'd5, 5'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall ready_in", ready_in, 0);
      cyc();
      check("stall data stable", data_out, held);
      check("stall free_count", free_count, 95);
    end
    ready_out = 1'b1;
    cyc();
    check("unstall pd_new", o_pdnew, 33);
    check("unstall rob_tag", o_rob, 1);
    valid_in = 1'b0;
    cyc();
    check("unstall drain", valid_out, 0);

    // Asynchronous reset mid-burst
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) send(OP_BR, 5'd0, 5'd1, 5'd1);
      else send(OP_ADD, 5'(i + 1), 5'd2, 5'd3);
      cyc();
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    valid_in = 1'b0;
    #1;
    check("async rst valid_out", valid_out, 0);
    check("async rst data_out", data_out, 0);
    check("async rst br_tag", br_tag_out, 0);
    check("async rst free_count", free_count, 96);
    check("async rst ckpt_count", ckpt_count, 0);
    cyc();
    reset_n = 1'b1;
    idle();
    cyc();
    check("post rst free_count", free_count, 96);
    send(OP_ADD, 5'd8, 5'd8, 5'd8);
    cyc();
    check("post rst pd_new", o_pdnew, 32);
    check("post rst rob_tag", o_rob, 0);
    idle();
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
